// File: rtl/fetch_cycle_measure_ctrl_pkg.sv
// Shared fetch-unit measurement types: controller state encoding, cycle/hit count
// types and the lane-index width helper.
package FetchUnitTypes;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned HIT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } MeasureState;

  typedef logic [CNT_WIDTH_DEF-1:0] MeasureCycle;
  typedef logic [HIT_WIDTH_DEF-1:0] HitCount;

  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 32'd1) ? $clog2(lanes) : 32'd1;
  endfunction

endpackage

// File: rtl/fetch_cycle_measure_ctrl_lane_hit_encoder.sv
// Combinational summary of the per-lane hit strobes: number of lanes hit,
// lowest hit lane index and an any-hit flag.
module lane_hit_encoder
  import FetchUnitTypes::*;
#(
  parameter int unsigned LANE_NUM = 2,
  parameter int unsigned PC_W     = $clog2(LANE_NUM + 1),
  parameter int unsigned IDX_W    = lane_idx_width(LANE_NUM)
) (
  input  logic [LANE_NUM-1:0] lane_hit_i,
  output logic [PC_W-1:0]     pop_o,
  output logic [IDX_W-1:0]    low_idx_o,
  output logic                any_o
);

  // Walk from the top lane down so the lowest set lane wins the index.
  always_comb begin
    pop_o     = '0;
    low_idx_o = '0;
    for (int i = LANE_NUM - 1; i >= 0; i--) begin
      low_idx_o = lane_hit_i[i] ? IDX_W'(i) : low_idx_o;
      pop_o     = pop_o + PC_W'(lane_hit_i[i]);
    end
  end

  assign any_o = |lane_hit_i;

endmodule

// File: rtl/fetch_cycle_measure_ctrl.sv
// Fetch-stage measurement controller: free-running cycle counter plus an
// IDLE/ARMED/RUNNING/DONE sequencer capturing begin/end cycles and lane hits.
module fetch_cycle_measure_ctrl
  import FetchUnitTypes::*;
#(
  parameter int unsigned LANE_NUM  = 2,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned HIT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmdStart,
  input  logic                                cmdStop,
  input  logic                                cmdClear,
  input  logic [LANE_NUM-1:0]                 laneHit,
  output logic [CNT_WIDTH-1:0]                cycleCount,
  output logic [CNT_WIDTH-1:0]                beginCycle,
  output logic [lane_idx_width(LANE_NUM)-1:0] beginLane,
  output logic                                beginValid,
  output logic [CNT_WIDTH-1:0]                endCycle,
  output logic [CNT_WIDTH-1:0]                elapsed,
  output logic [HIT_WIDTH-1:0]                hitCount,
  output logic                                hitOverflow,
  output logic [1:0]                          state,
  output logic                                done
);

  localparam int unsigned IDX_W = lane_idx_width(LANE_NUM);
  localparam int unsigned PC_W  = $clog2(LANE_NUM + 1);
  localparam int unsigned SUM_W = ((HIT_WIDTH > PC_W) ? HIT_WIDTH : PC_W) + 1;

  MeasureState          state_q;
  logic [CNT_WIDTH-1:0] cnt_q, begin_q, end_q, elapsed_q;
  logic [IDX_W-1:0]     lane_q;
  logic                 valid_q, ovf_q, done_q;
  logic [HIT_WIDTH-1:0] hit_q, hit_d;

  logic [PC_W-1:0]      pop_s;
  logic [IDX_W-1:0]     low_idx_s;
  logic                 any_s;
  logic [SUM_W-1:0]     hit_sum_s;
  logic                 hit_sat_s;

  lane_hit_encoder #(
    .LANE_NUM (LANE_NUM),
    .PC_W     (PC_W),
    .IDX_W    (IDX_W)
  ) u_enc (
    .lane_hit_i (laneHit),
    .pop_o      (pop_s),
    .low_idx_o  (low_idx_s),
    .any_o      (any_s)
  );

  // Saturating accumulate of this cycle's hits; the sum is one bit wider so
  // clamping can be detected without wrap.
  always_comb begin
    hit_sum_s = SUM_W'(hit_q) + SUM_W'(pop_s);
    if (hit_sum_s > SUM_W'({HIT_WIDTH{1'b1}})) begin
      hit_sat_s = 1'b1;
      hit_d     = {HIT_WIDTH{1'b1}};
    end else begin
      hit_sat_s = 1'b0;
      hit_d     = hit_sum_s[HIT_WIDTH-1:0];
    end
  end

  // Cycle counter and measurement sequencer with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      begin_q   <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      end_q     <= '0;
      elapsed_q <= '0;
      hit_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (cmdClear) begin
        state_q   <= IDLE;
        begin_q   <= '0;
        lane_q    <= '0;
        valid_q   <= 1'b0;
        end_q     <= '0;
        elapsed_q <= '0;
        hit_q     <= '0;
        ovf_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cmdStart) begin
              state_q   <= ARMED;
              begin_q   <= '0;
              lane_q    <= '0;
              valid_q   <= 1'b0;
              end_q     <= '0;
              elapsed_q <= '0;
              hit_q     <= '0;
              ovf_q     <= 1'b0;
              done_q    <= 1'b0;
            end
          end
          ARMED: begin
            if (cmdStop) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              valid_q   <= 1'b0;
              end_q     <= cnt_q;
              elapsed_q <= '0;
              hit_q     <= '0;
            end else if (any_s) begin
              // hit_q is zero here, so the accumulate yields this cycle's popcount.
              state_q <= RUNNING;
              begin_q <= cnt_q;
              lane_q  <= low_idx_s;
              valid_q <= 1'b1;
              hit_q   <= hit_d;
              ovf_q   <= ovf_q | hit_sat_s;
            end
          end
          RUNNING: begin
            if (cmdStop) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              end_q     <= cnt_q;
              elapsed_q <= cnt_q - begin_q;
            end else begin
              hit_q <= hit_d;
              ovf_q <= ovf_q | hit_sat_s;
            end
          end
          default: begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cycleCount  = cnt_q;
  assign beginCycle  = begin_q;
  assign beginLane   = lane_q;
  assign beginValid  = valid_q;
  assign endCycle    = end_q;
  assign elapsed     = elapsed_q;
  assign hitCount    = hit_q;
  assign hitOverflow = ovf_q;
  assign state       = state_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fetch_cycle_measure_ctrl.sv
// Directed bench: a default-width instance for the main flows and an
// 8-bit-counter / 2-bit-hit instance for wrap and saturation.
module tb_fetch_cycle_measure_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Default-width instance
  logic        m_rst, m_start, m_stop, m_clear;
  logic [1:0]  m_hit;
  logic [31:0] m_cnt, m_begin, m_end, m_elapsed;
  logic        m_lane, m_valid, m_ovf, m_done;
  logic [15:0] m_hitcnt;
  logic [1:0]  m_state;

  fetch_cycle_measure_ctrl u_main (
    .clk(clk), .rst(m_rst), .cmdStart(m_start), .cmdStop(m_stop), .cmdClear(m_clear),
    .laneHit(m_hit), .cycleCount(m_cnt), .beginCycle(m_begin), .beginLane(m_lane),
    .beginValid(m_valid), .endCycle(m_end), .elapsed(m_elapsed), .hitCount(m_hitcnt),
    .hitOverflow(m_ovf), .state(m_state), .done(m_done)
  );

  // Narrow instance
  logic        s_rst, s_start, s_stop, s_clear;
  logic [1:0]  s_hit;
  logic [7:0]  s_cnt, s_begin, s_end, s_elapsed;
  logic        s_lane, s_valid, s_ovf, s_done;
  logic [1:0]  s_hitcnt;
  logic [1:0]  s_state;

  fetch_cycle_measure_ctrl #(.LANE_NUM(2), .CNT_WIDTH(8), .HIT_WIDTH(2)) u_small (
    .clk(clk), .rst(s_rst), .cmdStart(s_start), .cmdStop(s_stop), .cmdClear(s_clear),
    .laneHit(s_hit), .cycleCount(s_cnt), .beginCycle(s_begin), .beginLane(s_lane),
    .beginValid(s_valid), .endCycle(s_end), .elapsed(s_elapsed), .hitCount(s_hitcnt),
    .hitOverflow(s_ovf), .state(s_state), .done(s_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_m(input logic [31:0] n);
    int k = 0;
    while (m_cnt !== n && k < 1000) begin
      step();
      k++;
    end
    chk("wait_main", m_cnt, n);
  endtask

  task automatic wait_s(input logic [7:0] n);
    int k = 0;
    while (s_cnt !== n && k < 1000) begin
      step();
      k++;
    end
    chk("wait_small", {24'd0, s_cnt}, {24'd0, n});
  endtask

  logic [31:0] c0;

  initial begin
    m_rst = 1'b1; m_start = 1'b0; m_stop = 1'b0; m_clear = 1'b0; m_hit = 2'b00;
    s_rst = 1'b1; s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0; s_hit = 2'b00;
    step(); step();
    chk("rst_cnt", m_cnt, 32'd0);
    chk("rst_state", {30'd0, m_state}, 32'd0);

    // Ten idle cycles after reset
    m_rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("idle_cnt", m_cnt, 32'd10);
    chk("idle_state", {30'd0, m_state}, 32'd0);
    chk("idle_begin", m_begin, 32'd0);
    chk("idle_hits", {16'd0, m_hitcnt}, 32'd0);
    chk("idle_elapsed", m_elapsed, 32'd0);
    chk("idle_done", {31'd0, m_done}, 32'd0);

    // Basic measurement: start@5, hits@8 (10) and @9 (11), stop@20
    m_rst = 1'b1; step(); m_rst = 1'b0;
    wait_m(32'd5);
    m_start = 1'b1; step(); m_start = 1'b0;
    chk("armed_state", {30'd0, m_state}, 32'd1);
    wait_m(32'd8);
    m_hit = 2'b10; step();
    chk("run_state", {30'd0, m_state}, 32'd2);
    chk("run_begin", m_begin, 32'd8);
    chk("run_lane", {31'd0, m_lane}, 32'd1);
    chk("run_valid", {31'd0, m_valid}, 32'd1);
    chk("run_hits1", {16'd0, m_hitcnt}, 32'd1);
    m_hit = 2'b11; step(); m_hit = 2'b00;
    chk("run_hits3", {16'd0, m_hitcnt}, 32'd3);
    wait_m(32'd20);
    m_stop = 1'b1; m_hit = 2'b11; step(); m_stop = 1'b0; m_hit = 2'b00;
    chk("done_state", {30'd0, m_state}, 32'd3);
    chk("done_flag", {31'd0, m_done}, 32'd1);
    chk("done_end", m_end, 32'd20);
    chk("done_elapsed", m_elapsed, 32'd12);
    chk("done_hits", {16'd0, m_hitcnt}, 32'd3);
    m_hit = 2'b01; step(); m_hit = 2'b00;
    chk("done_hold_hits", {16'd0, m_hitcnt}, 32'd3);

    // Re-arm from DONE with a same-cycle hit that must be ignored
    c0 = m_cnt;
    m_start = 1'b1; m_hit = 2'b01; step(); m_start = 1'b0;
    chk("rearm_state", {30'd0, m_state}, 32'd1);
    chk("rearm_hits", {16'd0, m_hitcnt}, 32'd0);
    chk("rearm_end", m_end, 32'd0);
    chk("rearm_elapsed", m_elapsed, 32'd0);
    step(); m_hit = 2'b00;
    chk("late_begin", m_begin, c0 + 32'd1);
    chk("late_lane", {31'd0, m_lane}, 32'd0);
    chk("late_hits", {16'd0, m_hitcnt}, 32'd1);
    m_start = 1'b1; step(); m_start = 1'b0;
    chk("start_in_run", {30'd0, m_state}, 32'd2);
    chk("start_in_run_begin", m_begin, c0 + 32'd1);

    // Clear beats stop in RUNNING
    c0 = m_cnt;
    m_clear = 1'b1; m_stop = 1'b1; m_hit = 2'b11; step();
    m_clear = 1'b0; m_stop = 1'b0; m_hit = 2'b00;
    chk("clr_state", {30'd0, m_state}, 32'd0);
    chk("clr_begin", m_begin, 32'd0);
    chk("clr_valid", {31'd0, m_valid}, 32'd0);
    chk("clr_hits", {16'd0, m_hitcnt}, 32'd0);
    chk("clr_end", m_end, 32'd0);
    chk("clr_cnt", m_cnt, c0 + 32'd1);

    // Stop in IDLE ignored, then stop in ARMED
    m_stop = 1'b1; step(); m_stop = 1'b0;
    chk("stop_idle", {30'd0, m_state}, 32'd0);
    m_start = 1'b1; step(); m_start = 1'b0;
    c0 = m_cnt;
    m_stop = 1'b1; step(); m_stop = 1'b0;
    chk("armstop_state", {30'd0, m_state}, 32'd3);
    chk("armstop_valid", {31'd0, m_valid}, 32'd0);
    chk("armstop_elapsed", m_elapsed, 32'd0);
    chk("armstop_end", m_end, c0);

    // Reset while RUNNING
    m_start = 1'b1; step(); m_start = 1'b0;
    m_hit = 2'b01; step(); m_hit = 2'b00;
    chk("pre_rst_state", {30'd0, m_state}, 32'd2);
    m_rst = 1'b1; step(); m_rst = 1'b0;
    chk("midrst_cnt", m_cnt, 32'd0);
    chk("midrst_state", {30'd0, m_state}, 32'd0);
    chk("midrst_begin", m_begin, 32'd0);
    chk("midrst_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_hits", {16'd0, m_hitcnt}, 32'd0);

    // Counter wrap on the 8-bit instance: hit@250, stop@4
    s_rst = 1'b0;
    wait_s(8'd248);
    s_start = 1'b1; step(); s_start = 1'b0;
    wait_s(8'd250);
    s_hit = 2'b01; step(); s_hit = 2'b00;
    chk("wrap_begin", {24'd0, s_begin}, 32'd250);
    wait_s(8'd4);
    s_stop = 1'b1; step(); s_stop = 1'b0;
    chk("wrap_state", {30'd0, s_state}, 32'd3);
    chk("wrap_end", {24'd0, s_end}, 32'd4);
    chk("wrap_elapsed", {24'd0, s_elapsed}, 32'd10);

    // Hit saturation on the 2-bit counter
    s_start = 1'b1; step(); s_start = 1'b0;
    s_hit = 2'b01;
    for (int i = 0; i < 5; i++) step();
    s_hit = 2'b00;
    chk("sat_hits", {30'd0, s_hitcnt}, 32'd3);
    chk("sat_ovf", {31'd0, s_ovf}, 32'd1);
    s_stop = 1'b1; step(); s_stop = 1'b0;
    chk("sat_ovf_sticky", {31'd0, s_ovf}, 32'd1);
    s_start = 1'b1; step(); s_start = 1'b0;
    chk("restart_hits", {30'd0, s_hitcnt}, 32'd0);
    chk("restart_ovf", {31'd0, s_ovf}, 32'd0);
    chk("restart_state", {30'd0, s_state}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
